// File: rtl/mmio_periph.sv
// ---------------------------------------------------------------------------
// mmio_periph: MMIO PWM bank with ADC capture; MMIO_AUTO_DUTY_EN adds ADC-follow MODE
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_periph #(
  parameter int          CHANNELS     = 4,
  parameter int          PWM_WIDTH    = 8,
  parameter int          SAMPLE_WIDTH = 10,
  parameter logic [15:0] BASE         = 16'h8000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic [15:0]             address,
  input  logic [15:0]             write_data,
  input  logic [15:0]             ram_read_data,
  input  logic [SAMPLE_WIDTH-1:0] adc_sample,
  input  logic                    adc_done,
  output logic [15:0]             read_data,
  output logic                    adc_reset,
  output logic [CHANNELS-1:0]     pulse
);

  localparam logic [7:0]           c_off_adc    = 8'h10;
  localparam logic [7:0]           c_off_status = 8'h11;
  localparam logic [7:0]           c_off_mode   = 8'h12;
  localparam logic [PWM_WIDTH-1:0] c_cnt_max    = '1;

  logic                    hit;
  logic [7:0]              off;
  logic                    wr_hit;
  logic                    rd_hit;
  logic [PWM_WIDTH-1:0]    cnt_q;
  logic [PWM_WIDTH-1:0]    duty_q [CHANNELS];
  logic [PWM_WIDTH-1:0]    act_q  [CHANNELS];
  logic [PWM_WIDTH-1:0]    act_d  [CHANNELS];
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic                    valid_q;
  logic                    status_q;
  logic                    adc_reset_q;
  logic                    rd_mmio_q;
  logic                    rd_ram_q;
  logic [15:0]             rd_val_q;
  logic [15:0]             rd_val_d;
  logic [CHANNELS-1:0]     mode_val;
  logic                    unused_wdata;

  assign hit          = (address[15:8] == BASE[15:8]);
  assign off          = address[7:0];
  assign wr_hit       = write_enable & hit;
  assign rd_hit       = read_enable & hit;
  assign unused_wdata = ^write_data;

`ifdef MMIO_AUTO_DUTY_EN
  logic [CHANNELS-1:0] mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= '0;
    end else if (wr_hit && (off == c_off_mode)) begin
      mode_q <= write_data[CHANNELS-1:0];
    end
  end

  assign mode_val = mode_q;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      act_d[ch] = mode_q[ch] ? sample_q[SAMPLE_WIDTH-1 -: PWM_WIDTH] : duty_q[ch];
    end
  end
`else
  assign mode_val = '0;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      act_d[ch] = duty_q[ch];
    end
  end
`endif

  // Active duty only changes at the wrap so every period runs to completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        duty_q[ch] <= '0;
        act_q[ch]  <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (wr_hit && (off == 8'(ch))) begin
          duty_q[ch] <= write_data[PWM_WIDTH-1:0];
        end
        if (cnt_q == c_cnt_max) begin
          act_q[ch] <= act_d[ch];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pulse
      assign pulse[g] = (cnt_q < act_q[g]);
    end
  endgenerate

  // A sample arriving in the same cycle as a STATUS read must not be lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_q    <= '0;
      valid_q     <= 1'b0;
      status_q    <= 1'b0;
      adc_reset_q <= 1'b0;
    end else begin
      adc_reset_q <= wr_hit && (off == c_off_adc);
      if (adc_done) begin
        sample_q <= adc_sample;
        valid_q  <= 1'b1;
        status_q <= 1'b1;
      end else if (rd_hit && (off == c_off_status)) begin
        status_q <= 1'b0;
      end
    end
  end

  assign adc_reset = adc_reset_q;

  always_comb begin
    rd_val_d = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (off == 8'(ch)) begin
        rd_val_d[PWM_WIDTH-1:0] = duty_q[ch];
      end
    end
    if (off == c_off_adc) begin
      rd_val_d[15]               = valid_q;
      rd_val_d[SAMPLE_WIDTH-1:0] = sample_q;
    end
    if (off == c_off_status) begin
      rd_val_d[0] = status_q;
    end
    if (off == c_off_mode) begin
      rd_val_d[CHANNELS-1:0] = mode_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_mmio_q <= 1'b0;
      rd_ram_q  <= 1'b0;
      rd_val_q  <= '0;
    end else begin
      rd_mmio_q <= rd_hit;
      rd_ram_q  <= read_enable & ~hit;
      rd_val_q  <= rd_hit ? rd_val_d : '0;
    end
  end

  assign read_data = rd_mmio_q ? rd_val_q : (rd_ram_q ? ram_read_data : 16'h0000);

endmodule

`default_nettype wire
